// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam int         FRAME_BITS = 11;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] data;
    } entry_t;

    // Frame is held with the start bit at index 0 and the stop bit at index 10.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] frame);
        return ~frame[0] & (^frame[9:1]) & frame[10];
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous FIFO with combinational head read; a push while full is
// accepted only if a pop happens in the same cycle.
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (level == '0);
    assign full     = (level == FULL_LEVEL);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign dropped  = push & full & ~do_pop;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH by themselves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the raw lines, deframes 11-bit frames,
// folds E0/F0 prefixes into flags and queues the resulting scan codes.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT     = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          code_ready,
    output logic                          code_valid,
    output logic [7:0]                    code_data,
    output logic                          code_break,
    output logic                          code_ext,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          err_clr
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   sample;
    logic                   bit_in;

    state_t                 state;
    state_t                 next_state;
    logic [3:0]             bit_cnt;
    logic [TW-1:0]          to_cnt;
    logic                   timed_out;
    logic [FRAME_BITS-1:0]  frame;
    logic                   ext_pending;
    logic                   brk_pending;

    logic                   push;
    logic                   set_err;
    logic                   set_ext;
    logic                   set_brk;
    logic                   clr_pend;

    entry_t                 push_entry;
    entry_t                 head_entry;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_dropped;

    // Idle PS/2 lines are high, so the chains reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign sample    = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
    assign bit_in    = data_sync[SYNC_STAGES-1];
    assign timed_out = (state == RECV) & ~sample & (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (sample && !bit_in) begin
                    next_state = RECV;
                end
            end
            RECV: begin
                if (sample && bit_cnt == 4'(FRAME_BITS - 1)) begin
                    next_state = CHECK;
                end else if (timed_out) begin
                    next_state = IDLE;
                end
            end
            CHECK:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        push     = 1'b0;
        set_err  = 1'b0;
        set_ext  = 1'b0;
        set_brk  = 1'b0;
        clr_pend = 1'b0;
        case (state)
            RECV: begin
                if (timed_out) begin
                    set_err  = 1'b1;
                    clr_pend = 1'b1;
                end
            end
            CHECK: begin
                if (!frame_ok(frame)) begin
                    set_err  = 1'b1;
                    clr_pend = 1'b1;
                end else if (frame[8:1] == PS2_EXT) begin
                    set_ext = 1'b1;
                end else if (frame[8:1] == PS2_BRK) begin
                    set_brk = 1'b1;
                end else begin
                    push     = 1'b1;
                    clr_pend = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Bits shift in at the top so the start bit ends at index 0 after 11 samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
            frame   <= '0;
        end else begin
            if (state != RECV || sample) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample && !bit_in) begin
                        frame   <= {bit_in, frame[FRAME_BITS-1:1]};
                        bit_cnt <= 4'd1;
                    end
                end
                RECV: begin
                    if (sample) begin
                        frame   <= {bit_in, frame[FRAME_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (timed_out) begin
                        bit_cnt <= '0;
                    end
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
        end else if (clr_pend) begin
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
        end else begin
            if (set_ext) begin
                ext_pending <= 1'b1;
            end
            if (set_brk) begin
                brk_pending <= 1'b1;
            end
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (set_err) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (fifo_dropped) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign push_entry = '{ext: ext_pending, brk: brk_pending, data: frame[8:1]};

    ps2_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (code_ready),
        .pop_data  (head_entry),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level),
        .dropped   (fifo_dropped)
    );

    assign code_valid = ~fifo_empty;
    assign code_data  = head_entry.data;
    assign code_break = head_entry.brk;
    assign code_ext   = head_entry.ext;

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: scan-code queue entries; power of two, at least 2.
REQ-002 Parameter SYNC_STAGES, default 3: synchroniser flops on ps2_clk and ps2_data; at least 2.
REQ-003 Parameter TIMEOUT, default 50000: clk cycles without a ps2_clk falling edge before an in-progress frame aborts.
REQ-004 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 ps2_clk  in  1  raw PS/2 clock line, asynchronous to clk.
REQ-008 ps2_data  in  1  raw PS/2 data line, asynchronous to clk.
REQ-009 code_ready  in  1  consumer accepts the head entry when code_valid is high.
REQ-010 code_valid  out  1  queue is non-empty.
REQ-011 code_data  out  8  scan-code byte at the queue head.
REQ-012 code_break  out  1  head entry was preceded by F0 (key release).
REQ-013 code_ext  out  1  head entry was preceded by E0 (extended key).
REQ-014 level  out  clog2(FIFO_DEPTH)+1  current queue occupancy.
REQ-015 frame_err  out  1  sticky flag: start, parity, stop or timeout error.
REQ-016 overflow  out  1  sticky flag: a decoded code was dropped because the queue was full.
REQ-017 err_clr  in  1  single-cycle pulse that clears frame_err and overflow.

Function
REQ-018 Both PS/2 inputs SHALL pass through SYNC_STAGES flops; a sample event is a 1-to-0 transition between the last two ps2_clk stages, and ps2_data is taken from its last stage in the same cycle.
REQ-019 FSM states: IDLE, RECV, CHECK; reset state IDLE.
REQ-020 IDLE: a sample event with data 0 SHALL go to RECV with the bit count at 1; a sample event with data 1 SHALL be ignored without raising an error.
REQ-021 RECV: each sample event SHALL store one bit, with data LSB-first, then parity, then stop; after the 11th bit the FSM SHALL enter CHECK.
REQ-022 CHECK (one cycle): the frame is valid when the start bit is 0, the XOR of the 8 data bits and the parity bit is 1 (odd parity), and the stop bit is 1; the FSM then returns to IDLE.
REQ-023 A valid byte 8'hE0 SHALL set ext_pending and push nothing; a valid byte 8'hF0 SHALL set brk_pending and push nothing.
REQ-024 Any other valid byte SHALL push {ext_pending, brk_pending, byte} and then clear both pending flags.
REQ-025 An invalid frame SHALL set frame_err, clear both pending flags, and push nothing.
REQ-026 In RECV, TIMEOUT cycles without a sample event SHALL abort the frame to IDLE, set frame_err, and clear both pending flags.
REQ-027 A pushed entry SHALL appear at code_valid, code_data, code_break and code_ext on the cycle after CHECK, when the queue was previously empty.
REQ-028 Pop SHALL occur when code_valid and code_ready are both high; the outputs SHALL show the next entry in the following cycle.
REQ-029 A push while full SHALL be accepted when a pop happens in the same cycle; otherwise the entry SHALL be dropped and overflow set, and level SHALL stay at FIFO_DEPTH.
REQ-030 Simultaneous push and pop when not full SHALL leave level unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 When err_clr coincides with a new error, the set SHALL win.

Reset
REQ-032 Reset SHALL clear the FSM to IDLE, the bit count to 0, the timeout counter, both pending flags, the FIFO pointers, level, frame_err and overflow; code_valid SHALL read 0 and the synchroniser flops SHALL reset to 1.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; the first frame accepted after reset SHALL begin with a fresh start bit.

Structure
REQ-034 Package ps2_pkg SHALL hold the FSM state enum, PS2_EXT=8'hE0, PS2_BRK=8'hF0, and FRAME_BITS=11.
REQ-035 The queue SHALL be the sub-module ps2_fifo, a synchronous FIFO with parameters WIDTH=10 and DEPTH=FIFO_DEPTH.

Verification
REQ-036 Frame carrying 8'h1C with parity 0, code_ready=1 -> one entry with data 1C, break 0, ext 0; frame_err stays 0.
REQ-037 Sequence E0, F0, 75 -> exactly one entry with data 75, break 1, ext 1; level peaks at 1.
REQ-038 Frame 8'h1C with the parity bit flipped -> no entry, frame_err=1; an err_clr pulse -> frame_err=0.
REQ-039 Start bit followed by 4 bits, then ps2_clk held high for 50000 cycles -> FSM returns to IDLE, frame_err=1; the next full frame 8'h29 is received correctly.
REQ-040 code_ready=0 and 9 make codes with FIFO_DEPTH=8 -> level=8, overflow=1, and drain order equals the first 8 codes.
REQ-041 Queue full with code_ready=1 asserted in the CHECK cycle of a 9th code -> no overflow, level stays 8.
